// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED sequencer: mode and state encodings,
// BREATHE duty table and the LED pattern generator.
package led_seq_pkg;

    localparam int STEP_W = 3;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_BLINK   = 2'b01,
        MODE_CHASE   = 2'b10,
        MODE_BREATHE = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ARM  = 2'b01,
        ST_RUN  = 2'b10
    } state_e;

    localparam logic [7:0] BREATHE_DUTY [8] = '{
        8'd0, 8'd64, 8'd128, 8'd192, 8'd255, 8'd192, 8'd128, 8'd64
    };

    // BREATHE compares the low count byte against the duty; 255 means fully on.
    function automatic logic [7:0] led_pattern(input mode_e mode,
                                               input logic [STEP_W-1:0] step,
                                               input logic [7:0] count_lo);
        logic [7:0] duty;
        logic [7:0] pat;
        duty = BREATHE_DUTY[step];
        pat  = 8'h00;
        case (mode)
            MODE_BLINK:   pat = step[0] ? 8'h00 : 8'hFF;
            MODE_CHASE:   pat = 8'h01 << step;
            MODE_BREATHE: pat = ((duty == 8'hFF) || (count_lo < duty)) ? 8'hFF : 8'h00;
            default:      pat = 8'h00;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/led_sequencer_step_tick_gen.sv
// Step timing against the upstream free-running count: anchor register,
// wrap-safe delta and single-tick resync when the count has jumped too far.
module step_tick_gen
    import led_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] current_count,
    input  logic [15:0] period,
    input  logic        load,
    input  logic        track,
    input  logic        cmp_en,
    output logic        tick_req
);

    logic [15:0] anchor_q, anchor_d;
    logic [15:0] eff_period;
    logic [15:0] delta;
    logic        over_one;
    logic        over_two;

    assign eff_period = (period == 16'd0) ? 16'd1 : period;
    assign delta      = current_count - anchor_q;
    // 17-bit compares so doubling the period can never overflow.
    assign over_one   = {1'b0, delta} >= {1'b0, eff_period};
    assign over_two   = {1'b0, delta} >= {eff_period, 1'b0};
    assign tick_req   = cmp_en & over_one;

    always_comb begin
        anchor_d = anchor_q;
        if (load || track) begin
            anchor_d = current_count;
        end else if (cmp_en && over_two) begin
            anchor_d = current_count;
        end else if (cmp_en && over_one) begin
            anchor_d = anchor_q + eff_period;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            anchor_q <= 16'd0;
        end else begin
            anchor_q <= anchor_d;
        end
    end

endmodule

// File: rtl/led_sequencer.sv
// LED sequencer top: IDLE/ARM/RUN control, step counter and registered
// LED pattern driven from the step and the selected mode.
module led_sequencer
    import led_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] current_count,
    input  logic [15:0] period,
    input  logic [1:0]  mode,
    input  logic        enable,
    output logic [7:0]  leds,
    output logic        step_tick,
    output logic [2:0]  step
);

    state_e              state_q, state_d;
    mode_e               mode_in;
    mode_e               mode_prev_q;
    logic [STEP_W-1:0]   step_q, step_d;
    logic                step_tick_q, step_tick_d;
    logic [7:0]          leds_q, leds_d;
    logic                arm_load;
    logic                track;
    logic                cmp_en;
    logic                tick_req;

    assign mode_in = mode_e'(mode);

    step_tick_gen u_tick_gen (
        .clk           (clk),
        .rst           (rst),
        .current_count (current_count),
        .period        (period),
        .load          (arm_load),
        .track         (track),
        .cmp_en        (cmp_en),
        .tick_req      (tick_req)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            step_q      <= '0;
            step_tick_q <= 1'b0;
            leds_q      <= 8'h00;
            mode_prev_q <= MODE_OFF;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            step_tick_q <= step_tick_d;
            leds_q      <= leds_d;
            mode_prev_q <= mode_in;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = enable ? ST_ARM : ST_IDLE;
            ST_ARM:  state_d = enable ? ST_RUN : ST_IDLE;
            ST_RUN:  state_d = enable ? ST_RUN : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        step_d      = '0;
        step_tick_d = 1'b0;
        leds_d      = 8'h00;
        arm_load    = 1'b0;
        track       = 1'b0;
        cmp_en      = 1'b0;
        case (state_q)
            ST_ARM: arm_load = 1'b1;
            ST_RUN: begin
                if (enable) begin
                    step_d = step_q;
                    leds_d = led_pattern(mode_in, step_q, current_count[7:0]);
                    // A mode switch restarts the pattern but keeps the time anchor.
                    if (mode_in != mode_prev_q) begin
                        step_d = '0;
                    end else if (mode_in == MODE_OFF) begin
                        track = 1'b1;
                    end else begin
                        cmp_en = 1'b1;
                        if (tick_req) begin
                            step_tick_d = 1'b1;
                            step_d      = step_q + 3'd1;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    assign leds      = leds_q;
    assign step_tick = step_tick_q;
    assign step      = step_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Directed self-checking bench for led_sequencer: a reset/arm vector table
// followed by hand-written multi-cycle sequences.
module tb_led_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] current_count;
    logic [15:0] period;
    logic [1:0]  mode;
    logic        enable;
    logic [7:0]  leds;
    logic        step_tick;
    logic [2:0]  step;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] M_OFF = 2'b00, M_BLINK = 2'b01, M_CHASE = 2'b10, M_BREATHE = 2'b11;

    typedef struct {
        logic        rst;
        logic        en;
        logic [15:0] count;
        logic [7:0]  leds;
        logic [2:0]  step;
        logic        tick;
    } vec_t;

    vec_t vt [6];

    always #5 clk = ~clk;

    led_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .current_count (current_count),
        .period        (period),
        .mode          (mode),
        .enable        (enable),
        .leds          (leds),
        .step_tick     (step_tick),
        .step          (step)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk3(input string name, input logic [7:0] l, input logic [2:0] s, input logic t);
        chk({name, ".leds"}, {8'h00, leds}, {8'h00, l});
        chk({name, ".step"}, {13'd0, step}, {13'd0, s});
        chk({name, ".tick"}, {15'd0, step_tick}, {15'd0, t});
    endtask

    task automatic cyc(input logic [15:0] c);
        current_count = c;
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [15:0] p, input logic [1:0] m, input logic [15:0] c0);
        rst    = 1'b1;
        enable = 1'b0;
        cyc(c0);
        rst    = 1'b0;
        enable = 1'b1;
        mode   = m;
        period = p;
        cyc(c0);
        cyc(c0);
    endtask

    initial begin
        int on_cycles;
        logic [7:0] exp_l;
        rst = 1'b1; enable = 1'b0; mode = M_CHASE; period = 16'd100; current_count = 16'h0000;

        vt[0] = '{1'b1, 1'b0, 16'h0000, 8'h00, 3'd0, 1'b0};
        vt[1] = '{1'b1, 1'b1, 16'h0000, 8'h00, 3'd0, 1'b0};
        vt[2] = '{1'b0, 1'b0, 16'h0000, 8'h00, 3'd0, 1'b0};
        vt[3] = '{1'b0, 1'b0, 16'h0005, 8'h00, 3'd0, 1'b0};
        vt[4] = '{1'b0, 1'b1, 16'h000F, 8'h00, 3'd0, 1'b0};
        vt[5] = '{1'b0, 1'b1, 16'h0010, 8'h00, 3'd0, 1'b0};

        for (int i = 0; i < 6; i++) begin
            rst    = vt[i].rst;
            enable = vt[i].en;
            cyc(vt[i].count);
            chk3($sformatf("vec%0d", i), vt[i].leds, vt[i].step, vt[i].tick);
        end

        // CHASE, period 100, anchored at 0x0010: ticks at 0x0074, 0x00D8, ...
        for (int c = 'h11; c <= 'h10 + 100 * 9 + 1; c++) begin
            int k, kp;
            k  = (c - 16) / 100;
            kp = (c - 17) / 100;
            cyc(16'(c));
            exp_l = 8'h01 << (kp % 8);
            chk3($sformatf("chase@%0h", c), exp_l, 3'(k % 8), ((c - 16) % 100) == 0);
        end

        // Count jumps, resync and period change
        start_run(16'd10, M_CHASE, 16'd100);
        cyc(16'd105); chk3("jmp105", 8'h01, 3'd0, 1'b0);
        cyc(16'd155); chk3("jmp155", 8'h01, 3'd1, 1'b1);
        cyc(16'd156); chk3("jmp156", 8'h02, 3'd1, 1'b0);
        for (int c = 157; c <= 164; c++) begin
            cyc(16'(c)); chk("jmp_quiet.tick", {15'd0, step_tick}, 16'd0);
        end
        cyc(16'd165); chk3("jmp165", 8'h02, 3'd2, 1'b1);
        cyc(16'd180); chk3("jmp180", 8'h04, 3'd3, 1'b1);
        cyc(16'd185); chk3("jmp185", 8'h08, 3'd4, 1'b1);
        cyc(16'd205); chk3("resync205", 8'h10, 3'd5, 1'b1);
        cyc(16'd214); chk3("resync214", 8'h20, 3'd5, 1'b0);
        cyc(16'd215); chk3("resync215", 8'h20, 3'd6, 1'b1);
        period = 16'd20;
        cyc(16'd230); chk3("per230", 8'h40, 3'd6, 1'b0);
        cyc(16'd235); chk3("per235", 8'h40, 3'd7, 1'b1);
        enable = 1'b0;
        cyc(16'd236); chk3("dis236", 8'h00, 3'd0, 1'b0);
        cyc(16'd237); chk3("dis237", 8'h00, 3'd0, 1'b0);

        // BLINK across the 16-bit wrap, then period 0 and a held count
        start_run(16'd4, M_BLINK, 16'hFFFE);
        cyc(16'hFFFF); chk3("wrapFFFF", 8'hFF, 3'd0, 1'b0);
        cyc(16'h0000); chk3("wrap0000", 8'hFF, 3'd0, 1'b0);
        cyc(16'h0001); chk3("wrap0001", 8'hFF, 3'd0, 1'b0);
        cyc(16'h0002); chk3("wrap0002", 8'hFF, 3'd1, 1'b1);
        cyc(16'h0003); chk3("wrap0003", 8'h00, 3'd1, 1'b0);
        cyc(16'h0005); chk3("wrap0005", 8'h00, 3'd1, 1'b0);
        cyc(16'h0006); chk3("wrap0006", 8'h00, 3'd2, 1'b1);
        cyc(16'h0007); chk3("wrap0007", 8'hFF, 3'd2, 1'b0);
        period = 16'd0;
        cyc(16'h0007); chk3("p0_tick", 8'hFF, 3'd3, 1'b1);
        cyc(16'h0007); chk3("hold1", 8'h00, 3'd3, 1'b0);
        cyc(16'h0007); chk3("hold2", 8'h00, 3'd3, 1'b0);

        // BREATHE duty 64 sweep, then OFF tracking and return to CHASE
        start_run(16'h0100, M_BREATHE, 16'h0000);
        cyc(16'h0100); chk3("br_tick", 8'h00, 3'd1, 1'b1);
        on_cycles = 0;
        for (int i = 0; i < 256; i++) begin
            cyc(16'(16'h0100 + i));
            if (leds == 8'hFF) on_cycles++;
            chk3($sformatf("br%0d", i), (i < 64) ? 8'hFF : 8'h00, 3'd1, 1'b0);
        end
        chk("br_on_cycles", 16'(on_cycles), 16'd64);
        mode = M_OFF;
        cyc(16'h0200); chk3("off_chg", 8'h00, 3'd0, 1'b0);
        cyc(16'h0300); chk3("off_track", 8'h00, 3'd0, 1'b0);
        mode = M_CHASE;
        cyc(16'h0300); chk3("on_chg", 8'h01, 3'd0, 1'b0);
        cyc(16'h03FF); chk3("on_3FF", 8'h01, 3'd0, 1'b0);
        cyc(16'h0400); chk3("on_400", 8'h01, 3'd1, 1'b1);

        // CHASE to step 5, mode switch to BLINK, reset mid-RUN
        start_run(16'd1, M_CHASE, 16'd0);
        for (int c = 1; c <= 5; c++) begin
            cyc(16'(c));
            exp_l = 8'h01 << (c - 1);
            chk3($sformatf("fast%0d", c), exp_l, 3'(c), 1'b1);
        end
        cyc(16'd5); chk3("at5", 8'h20, 3'd5, 1'b0);
        mode = M_BLINK;
        cyc(16'd5); chk3("mchg", 8'h00, 3'd0, 1'b0);
        cyc(16'd5); chk3("mchg_next", 8'hFF, 3'd0, 1'b0);
        rst = 1'b1;
        cyc(16'd6); chk3("rst_run", 8'h00, 3'd0, 1'b0);
        rst = 1'b0; enable = 1'b0;
        cyc(16'd7); chk3("post_rst", 8'h00, 3'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_sequencer.md
LED_SEQUENCER -- requirements
Module: led_sequencer

Interface
REQ-001 SHALL have port clk  in  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-003 SHALL have port current_count  in  16  free-running count from upstream counter; wraps 0xFFFF->0x0000; may hold between clocks.
REQ-004 SHALL have port period  in  16  step interval in count units; 0 treated as 1.
REQ-005 SHALL have port mode  in  2  00 OFF, 01 BLINK, 10 CHASE, 11 BREATHE.
REQ-006 SHALL have port enable  in  1  sequencer run request, level-sensitive.
REQ-007 SHALL have port leds  out  8  registered LED drive.
REQ-008 SHALL have port step_tick  out  1  registered one-cycle pulse per step advance.
REQ-009 SHALL have port step  out  3  registered current step index.

Function
REQ-010 SHALL implement FSM states IDLE, ARM, RUN.
REQ-011 IDLE: leds=0, step=0, step_tick=0; enable=1 -> ARM.
REQ-012 ARM (one cycle): anchor<=current_count, step<=0; -> RUN; enable=0 -> IDLE instead.
REQ-013 RUN: enable=0 -> IDLE; leds=0 on the following edge.
REQ-014 In RUN, delta = (current_count - anchor) mod 2^16, 16-bit unsigned.
REQ-015 In RUN, delta >= eff_period: step_tick<=1, step<=step+1 (wraps 7->0), anchor<=anchor+eff_period (mod 2^16).
REQ-016 delta >= 2*eff_period (17-bit compare, no overflow): single tick, anchor<=current_count (resync, no burst catch-up).
REQ-017 At most one step_tick per clock; step_tick=0 all other cycles.
REQ-018 mode=OFF in RUN: leds=0; no tick, no step advance; anchor tracks current_count.
REQ-019 Mode change in RUN (mode != previous registered mode): step<=0, no tick that cycle, anchor kept.
REQ-020 leds registered from step and mode: new pattern appears one cycle after step_tick high.
REQ-021 BLINK: leds=0xFF when step[0]=0, else 0x00.
REQ-022 CHASE: leds = one-hot, bit index = step.
REQ-023 BREATHE: duty per step {0,64,128,192,255,192,128,64}; all leds=1 when current_count[7:0] < duty, all 1 when duty=255, all 0 when duty=0.
REQ-024 period change mid-RUN: effective on next compare; anchor unchanged.
REQ-025 current_count held constant: delta constant; no spurious ticks.

Reset
REQ-026 rst=1 at rising edge: state=IDLE, anchor=0, step=0, leds=0, step_tick=0, previous mode=OFF.
REQ-027 rst overrides all inputs including enable; asserted mid-RUN, outputs zero on that edge.
REQ-028 First edge with rst=0 behaves as IDLE.

Structure
REQ-029 Shared package led_seq_pkg: mode encoding, FSM state type, 8-entry BREATHE duty table, step width constant (3).
REQ-030 Sub-module step_tick_gen: anchor register, delta/compare, resync logic; outputs tick request to FSM.
REQ-031 No internal clock division or gated clocks; upstream counter is the only timebase.

Verification
REQ-032 rst=1 2 cycles, then enable=0 -> leds=0x00, step=0, step_tick=0 on every cycle.
REQ-033 CHASE, period=100, count +1/cycle, enable rise at count=0x0010 -> ticks at counts 0x0074, 0x00D8, ...; leds 0x01,0x02,0x04 ... 0x80, 0x01 one cycle after each tick.
REQ-034 BLINK, period=4, anchor=0xFFFE, count wraps through 0x0000 -> tick at count 0x0002; leds toggle 0xFF/0x00.
REQ-035 RUN, period=10, count jumps by 50 in one cycle -> exactly one step_tick; anchor = new count; next tick 10 counts later.
REQ-036 BREATHE at step=1 (duty 64), count[7:0] sweeps 0..255 -> leds=0xFF for 64 cycles, 0x00 for 192.
REQ-037 CHASE at step=5; mode->BLINK -> step=0, no tick; leds=0xFF next cycle; rst mid-RUN -> all outputs 0 same edge.
